plugboard_pairs: RTL and testbench
==================================

Name: plugboard_pairs

Overview:
Programmable Enigma plugboard (Steckerbrett) holding up to MAX_PAIRS letter-swap pairs.
- Forward position: between the keyboard scan decoder and the rotor/reflector stage.
- Return position: a second instance sits between the rotor/reflector stage and the VGA gui.
- Configuration: pairs are entered as keystroke pairs while cfg_mode is high.
- Run mode: each one-hot letter is swapped (or passed through) and delivered one cycle later with a strobe.

Parameters:
MAX_PAIRS, 10, number of pair slots (1..15)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
in  input  26  one-hot letter (bit0=A .. bit25=Z); all-zero means no letter
in_valid  input  1  single-cycle strobe qualifying in
cfg_mode  input  1  1 = configure pairs, 0 = run (encipher)
clear  input  1  single-cycle synchronous request to delete all pairs
out  output  26  one-hot swapped letter
out_valid  output  1  single-cycle strobe qualifying out
pair_count  output  4  number of stored pairs
pending  output  1  first letter of a pair latched, second awaited
err  output  1  single-cycle strobe on a rejected input

Behaviour:
- Reset (reset=0, asynchronous): all slots invalid, pair_count=0, state IDLE, out=0, out_valid=0, pending=0, err=0.
- Input decode: in with exactly one bit set gives a 5-bit index.
  - in=0 with in_valid: ignored silently, no strobes.
  - Multi-hot in with in_valid: ignored, err=1 next cycle.
- Storage: MAX_PAIRS slots {a[4:0], b[4:0], v}. A letter is "plugged" if it equals a or b of any valid slot.
- Run mode (cfg_mode=0), valid in_valid:
  - Next cycle out = one-hot partner if plugged, else out = in; out_valid=1 for exactly one cycle.
  - out holds its value until the next out_valid.
  - Latency is exactly 1 cycle. Back-to-back strobes on consecutive cycles give back-to-back outputs.
- Config mode: out_valid is never asserted; out is unchanged. FSM states IDLE and FIRST:
  - IDLE + valid letter: latch it as first, go to FIRST, pending=1.
  - IDLE + letter already plugged: err, stay IDLE.
  - IDLE + pair_count==MAX_PAIRS: err, stay IDLE.
  - FIRST + valid second letter, not plugged and different from first: write into the lowest invalid slot, pair_count+1 next cycle, go IDLE, pending=0.
  - FIRST + second letter equal to first, or already plugged: err, discard pair, go IDLE.
  - FIRST + cfg_mode dropping to 0: discard pair, go IDLE the next cycle, no err.
- clear=1: all slots invalid, pair_count=0, go IDLE next cycle. clear wins over a same-cycle in_valid, which is dropped with no err and no out_valid.
- err and out_valid are never asserted in the same cycle.
- Asynchronous reset asserted mid-pair or mid-output: everything returns to reset values immediately.

Test Plan:
1. After reset, run mode, in=A(26'h1) -> next cycle out=26'h1, out_valid=1 for one cycle; pair_count=0.
2. cfg_mode=1, key A then key B (26'h2) -> pending=1 after A, 0 after B; pair_count=1. Run mode: A->26'h2, B->26'h1, C(26'h4)->26'h4, each 1-cycle latency.
3. Configure 10 disjoint pairs (A-B .. S-T), then key U -> err pulse, pair_count stays 10, pending stays 0. Key A in IDLE -> err (already plugged).
4. In config: key C then C -> err, pending=0. Key C then A (plugged) -> err, pair_count unchanged. Multi-hot 26'h3 -> err, no state change.
5. With pairs stored, assert clear and in_valid in the same cycle in run mode -> no out_valid, no err; pair_count=0 next cycle. Key A -> out=26'h1.
6. Key D in config mode (pending=1), drop cfg_mode -> pending=0 next cycle, pair_count unchanged. Assert reset while pending -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/plugboard_pairs_if.sv
// Plugboard pairs bus.
// Carries the letter input, the mode and clear controls, and the swapped-letter
// result with its status.
//   master: drives in, in_valid, cfg_mode, clear; observes the results.
//   slave : the plugboard itself.
interface plugboard_pairs_if;
  logic [25:0] in;
  logic        in_valid;
  logic        cfg_mode;
  logic        clear;
  logic [25:0] out;
  logic        out_valid;
  logic [3:0]  pair_count;
  logic        pending;
  logic        err;

  modport master (
    output in, in_valid, cfg_mode, clear,
    input  out, out_valid, pair_count, pending, err
  );

  modport slave (
    input  in, in_valid, cfg_mode, clear,
    output out, out_valid, pair_count, pending, err
  );
endinterface

// File: rtl/plugboard_pairs.sv
// Enigma plugboard (Steckerbrett) with up to MAX_PAIRS programmable letter swaps.
// Config mode: pairs are keyed in as two one-hot letters.
// Run mode: each letter is swapped with its partner, or passed through, and
// delivered one cycle later.
// Ports:
//   CLOCK_50 - system clock
//   reset    - asynchronous, active-low reset
//   bus      - plugboard_pairs_if.slave carrying:
//                in/in_valid       one-hot letter in
//                cfg_mode/clear    mode select and delete-all request
//                out/out_valid     swapped letter out
//                pair_count        stored pair count
//                pending           pair half-entered
//                err               rejected-input strobe
module plugboard_pairs #(
  parameter int unsigned MAX_PAIRS = 10
) (
  input logic              CLOCK_50,
  input logic              reset,
  plugboard_pairs_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFirst} state_e;

  state_e      state_q;
  logic [4:0]  first_q;
  logic [4:0]  slot_a_q [MAX_PAIRS];
  logic [4:0]  slot_b_q [MAX_PAIRS];
  logic [MAX_PAIRS-1:0] slot_v_q;
  logic [3:0]  pair_count_q;
  logic [25:0] out_q;
  logic        out_valid_q;
  logic        pending_q;
  logic        err_q;

  logic        is_zero;
  logic        is_onehot;
  logic [4:0]  letter_idx;
  logic        plugged;
  logic [4:0]  partner;
  logic [MAX_PAIRS-1:0] free_sel;
  logic        free_found;
  logic        full;

  assign is_zero   = (bus.in == '0);
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign is_onehot = !is_zero && ((bus.in & (bus.in - 26'd1)) == '0);
  assign full      = (pair_count_q == 4'(MAX_PAIRS));

  always_comb begin
    letter_idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (bus.in[i]) letter_idx = 5'(i);
    end
  end

  // Partner lookup across all valid slots; unplugged letters map to themselves.
  always_comb begin
    plugged = 1'b0;
    partner = letter_idx;
    for (int s = 0; s < int'(MAX_PAIRS); s++) begin
      if (slot_v_q[s] && (slot_a_q[s] == letter_idx)) begin
        plugged = 1'b1;
        partner = slot_b_q[s];
      end
      if (slot_v_q[s] && (slot_b_q[s] == letter_idx)) begin
        plugged = 1'b1;
        partner = slot_a_q[s];
      end
    end
  end

  // One-hot select of the lowest invalid slot.
  always_comb begin
    free_sel   = '0;
    free_found = 1'b0;
    for (int s = 0; s < int'(MAX_PAIRS); s++) begin
      if (!slot_v_q[s] && !free_found) begin
        free_sel[s] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      first_q      <= '0;
      slot_v_q     <= '0;
      pair_count_q <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
      for (int s = 0; s < int'(MAX_PAIRS); s++) begin
        slot_a_q[s] <= '0;
        slot_b_q[s] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (bus.clear) begin
        // Clear swallows any same-cycle letter.
        slot_v_q     <= '0;
        pair_count_q <= '0;
        state_q      <= StIdle;
        pending_q    <= 1'b0;
      end else if (!bus.cfg_mode) begin
        // Leaving config mode abandons a half-entered pair.
        state_q   <= StIdle;
        pending_q <= 1'b0;
        if (bus.in_valid && !is_zero) begin
          if (!is_onehot) begin
            err_q <= 1'b1;
          end else begin
            out_q       <= 26'd1 << partner;
            out_valid_q <= 1'b1;
          end
        end
      end else if (bus.in_valid && !is_zero) begin
        if (!is_onehot) begin
          err_q <= 1'b1;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (plugged || full) begin
                err_q <= 1'b1;
              end else begin
                first_q   <= letter_idx;
                state_q   <= StFirst;
                pending_q <= 1'b1;
              end
            end
            StFirst: begin
              state_q   <= StIdle;
              pending_q <= 1'b0;
              if (plugged || (letter_idx == first_q) || !free_found) begin
                err_q <= 1'b1;
              end else begin
                for (int s = 0; s < int'(MAX_PAIRS); s++) begin
                  if (free_sel[s]) begin
                    slot_a_q[s] <= first_q;
                    slot_b_q[s] <= letter_idx;
                    slot_v_q[s] <= 1'b1;
                  end
                end
                pair_count_q <= pair_count_q + 4'd1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.pair_count = pair_count_q;
  assign bus.pending    = pending_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_plugboard_pairs.sv
// Self-checking bench for plugboard_pairs: table-driven config sequences, a
// letter-map model feeding a scoreboard queue for run-mode outputs, and
// hand-written sequences for clear, mode drop and asynchronous reset.
module tb_plugboard_pairs;

  logic clk;
  logic rst_n;
  plugboard_pairs_if bus ();

  plugboard_pairs #(.MAX_PAIRS(10)) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [25:0] in;
    logic        e_err;
    logic        e_pend;
    logic [3:0]  e_cnt;
  } cvec_t;

  int checks = 0;
  int errors = 0;
  int pmap [26];            // partner letter index, -1 when unplugged
  logic [25:0] sb [$];      // expected run-mode outputs
  logic sent;               // a run-mode letter was accepted at the last posedge
  logic prev_pend;
  int   first_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [25:0] v);
    int r = -1;
    for (int i = 0; i < 26; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [25:0] swap(input logic [25:0] v);
    int i = idx_of(v);
    logic [25:0] r = 26'd1;
    if (pmap[i] < 0) return v;
    return r << pmap[i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 26; i++) pmap[i] = -1;
    prev_pend = 1'b0;
  endtask

  task automatic drive(input logic [25:0] v, input logic cfg, input logic clr);
    @(negedge clk);
    bus.in       = v;
    bus.in_valid = 1'b1;
    bus.cfg_mode = cfg;
    bus.clear    = clr;
    if (!cfg && !clr && $onehot(v)) sb.push_back(swap(v));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in       = '0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic apply_cfg(input cvec_t v, input string name);
    drive(v.in, 1'b1, 1'b0);
    idle();
    chk({name, " err"}, 32'(bus.err), 32'(v.e_err));
    chk({name, " pending"}, 32'(bus.pending), 32'(v.e_pend));
    chk({name, " pair_count"}, 32'(bus.pair_count), 32'(v.e_cnt));
    if (v.e_pend && !prev_pend) first_l = idx_of(v.in);
    else if (prev_pend && !v.e_err && !v.e_pend && $onehot(v.in)) begin
      pmap[first_l]      = idx_of(v.in);
      pmap[idx_of(v.in)] = first_l;
    end
    prev_pend = v.e_pend;
  endtask

  // Latency check: out_valid must follow an accepted run-mode letter by one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent = 1'b0;
    else sent = bus.in_valid && !bus.cfg_mode && !bus.clear && $onehot(bus.in);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid latency", 32'(bus.out_valid), 32'(sent));
      if (bus.out_valid && bus.err) chk("err with out_valid", 32'(1), 32'(0));
      if (bus.out_valid) begin
        if (sb.size() == 0) chk("unexpected out_valid", 32'(1), 32'(0));
        else chk("out letter", 32'(bus.out), 32'(sb.pop_front()));
      end
    end
  end

  cvec_t tab_a [$];
  cvec_t tab_b [$];

  initial begin
    // Pairs A-B .. S-T, then two rejected keys.
    tab_a.push_back('{26'h1, 1'b0, 1'b1, 4'd0});
    tab_a.push_back('{26'h2, 1'b0, 1'b0, 4'd1});
    for (int k = 1; k < 10; k++) begin
      tab_a.push_back('{26'd1 << (2 * k), 1'b0, 1'b1, 4'(k)});
      tab_a.push_back('{26'd1 << (2 * k + 1), 1'b0, 1'b0, 4'(k + 1)});
    end
    tab_a.push_back('{26'd1 << 20, 1'b1, 1'b0, 4'd10});  // U with table full
    tab_a.push_back('{26'h1, 1'b1, 1'b0, 4'd10});        // A already plugged
    // After clear: pair A-B, then the rejection corner cases, then C-D.
    tab_b = '{
      '{26'h1, 1'b0, 1'b1, 4'd0},
      '{26'h2, 1'b0, 1'b0, 4'd1},
      '{26'h4, 1'b0, 1'b1, 4'd1},
      '{26'h4, 1'b1, 1'b0, 4'd1},  // C then C
      '{26'h4, 1'b0, 1'b1, 4'd1},
      '{26'h1, 1'b1, 1'b0, 4'd1},  // C then plugged A
      '{26'h3, 1'b1, 1'b0, 4'd1},  // multi-hot in idle
      '{26'h4, 1'b0, 1'b1, 4'd1},
      '{26'h3, 1'b1, 1'b1, 4'd1},  // multi-hot keeps the first letter
      '{26'h8, 1'b0, 1'b0, 4'd2},
      '{26'h0, 1'b0, 1'b0, 4'd2}   // empty key ignored
    };

    model_clear();
    first_l      = 0;
    rst_n        = 1'b0;
    bus.in       = '0;
    bus.in_valid = 1'b0;
    bus.cfg_mode = 1'b0;
    bus.clear    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset out", 32'(bus.out), 32'(0));
    chk("reset out_valid", 32'(bus.out_valid), 32'(0));
    chk("reset pair_count", 32'(bus.pair_count), 32'(0));
    chk("reset pending", 32'(bus.pending), 32'(0));
    chk("reset err", 32'(bus.err), 32'(0));
    rst_n = 1'b1;

    // Pass-through with no pairs.
    drive(26'h1, 1'b0, 1'b0);
    idle();
    chk("run A pair_count", 32'(bus.pair_count), 32'(0));

    // Fill the table and walk every letter back-to-back.
    for (int i = 0; i < tab_a.size(); i++) apply_cfg(tab_a[i], $sformatf("cfgA[%0d]", i));
    for (int i = 0; i < 26; i++) drive(26'd1 << i, 1'b0, 1'b0);
    idle();
    drive(26'h3, 1'b0, 1'b0);
    idle();
    chk("run multi-hot err", 32'(bus.err), 32'(1));

    // Clear in config mode, then the rejection sequences.
    drive(26'h0, 1'b1, 1'b1);
    idle();
    model_clear();
    chk("clear pair_count", 32'(bus.pair_count), 32'(0));
    for (int i = 0; i < tab_b.size(); i++) apply_cfg(tab_b[i], $sformatf("cfgB[%0d]", i));
    drive(26'h1, 1'b0, 1'b0);
    drive(26'h4, 1'b0, 1'b0);
    drive(26'h10, 1'b0, 1'b0);
    idle();

    // Clear beats a same-cycle run-mode letter.
    drive(26'h1, 1'b0, 1'b1);
    idle();
    model_clear();
    chk("clear+valid err", 32'(bus.err), 32'(0));
    chk("clear+valid out_valid", 32'(bus.out_valid), 32'(0));
    chk("clear+valid pair_count", 32'(bus.pair_count), 32'(0));
    drive(26'h1, 1'b0, 1'b0);
    idle();

    // Dropping cfg_mode abandons the half pair.
    apply_cfg('{26'h8, 1'b0, 1'b1, 4'd0}, "cfg D");
    @(negedge clk);
    bus.cfg_mode = 1'b0;
    @(negedge clk);
    chk("mode drop pending", 32'(bus.pending), 32'(0));
    chk("mode drop pair_count", 32'(bus.pair_count), 32'(0));
    chk("mode drop err", 32'(bus.err), 32'(0));
    prev_pend = 1'b0;

    // Asynchronous reset while pending, between clock edges.
    apply_cfg('{26'h8, 1'b0, 1'b1, 4'd0}, "cfg D again");
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out", 32'(bus.out), 32'(0));
    chk("async reset pending", 32'(bus.pending), 32'(0));
    chk("async reset pair_count", 32'(bus.pair_count), 32'(0));
    chk("async reset out_valid", 32'(bus.out_valid), 32'(0));
    chk("async reset err", 32'(bus.err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    bus.cfg_mode = 1'b0;
    drive(26'h10, 1'b0, 1'b0);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
